// File: rtl/rom_fetch_unit.sv
// Sequential instruction fetch from a 1-cycle-latency single-port ROM.
// Words are tagged with their PC and handed downstream through a 2-entry valid/ready buffer.
module rom_fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] src_rom_address,
  output logic                     src_rom_ren,
  output logic                     src_rom_cen,
  input  logic [DATA_WIDTH-1:0]    sink_rom_data,
  input  logic                     sink_enable,
  input  logic                     sink_branch,
  input  logic [ADDRESS_WIDTH-1:0] sink_branch_target,
  output logic [DATA_WIDTH-1:0]    src_instr,
  output logic [ADDRESS_WIDTH-1:0] src_instr_pc,
  output logic                     src_valid,
  input  logic                     sink_ready
);

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     ren_q, ren_d;
  logic                     pend_q, pend_d;
  logic [ADDRESS_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]               count_q, count_d;
  logic [DATA_WIDTH-1:0]    head_data_q, head_data_d;
  logic [ADDRESS_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [DATA_WIDTH-1:0]    tail_data_q, tail_data_d;
  logic [ADDRESS_WIDTH-1:0] tail_pc_q, tail_pc_d;

  logic       push;
  logic       pop;
  logic [1:0] count_popped;

  assign push = pend_q;
  assign pop  = (count_q != 2'd0) && sink_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    addr_d       = addr_q;
    ren_d        = 1'b0;
    pend_d       = 1'b0;
    pend_pc_d    = pend_pc_q;
    count_d      = count_q;
    head_data_d  = head_data_q;
    head_pc_d    = head_pc_q;
    tail_data_d  = tail_data_q;
    tail_pc_d    = tail_pc_q;
    count_popped = count_q - {1'b0, pop};

    if (sink_branch) begin
      // Flush: buffered words, the in-flight response and any handshake are all dropped.
      count_d = 2'd0;
      if (sink_enable) begin
        addr_d     = sink_branch_target;
        ren_d      = 1'b1;
        pend_d     = 1'b1;
        pend_pc_d  = sink_branch_target;
        fetch_pc_d = sink_branch_target + 1'b1;
      end else begin
        fetch_pc_d = sink_branch_target;
      end
    end else begin
      if (pop) begin
        head_data_d = tail_data_q;
        head_pc_d   = tail_pc_q;
      end
      if (push) begin
        if (count_popped == 2'd0) begin
          head_data_d = sink_rom_data;
          head_pc_d   = pend_pc_q;
        end else begin
          tail_data_d = sink_rom_data;
          tail_pc_d   = pend_pc_q;
        end
      end
      count_d = count_popped + {1'b0, push};

      // Only issue when the response is guaranteed a free slot next cycle.
      if (sink_enable && (count_d <= 2'd1)) begin
        addr_d     = fetch_pc_q;
        ren_d      = 1'b1;
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      addr_q      <= RESET_PC;
      ren_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_pc_q   <= RESET_PC;
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      tail_data_q <= '0;
      tail_pc_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      ren_q       <= ren_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      tail_data_q <= tail_data_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

  assign src_rom_address = addr_q;
  assign src_rom_ren     = ren_q;
  assign src_rom_cen     = ren_q;
  assign src_valid       = (count_q != 2'd0);
  assign src_instr       = head_data_q;
  assign src_instr_pc    = head_pc_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: behavioural ROMs, a PC scoreboard on the main instance,
// and a second instance with RESET_PC = 0xFFFE for the wrap case.
module tb_rom_fetch_unit;

  logic        clk;
  logic        rst;
  logic        sink_enable;
  logic        sink_branch;
  logic [15:0] sink_branch_target;
  logic        sink_ready;

  logic [15:0] rom_addr, rom_data, instr, instr_pc;
  logic        rom_ren, rom_cen, valid;
  logic [15:0] w_rom_addr, w_rom_data, w_instr, w_instr_pc;
  logic        w_rom_ren, w_rom_cen, w_valid;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic        mon_en = 1'b0;

  rom_fetch_unit #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .src_rom_address(rom_addr), .src_rom_ren(rom_ren), .src_rom_cen(rom_cen),
    .sink_rom_data(rom_data), .sink_enable(sink_enable), .sink_branch(sink_branch),
    .sink_branch_target(sink_branch_target),
    .src_instr(instr), .src_instr_pc(instr_pc), .src_valid(valid), .sink_ready(sink_ready)
  );

  rom_fetch_unit #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst),
    .src_rom_address(w_rom_addr), .src_rom_ren(w_rom_ren), .src_rom_cen(w_rom_cen),
    .sink_rom_data(w_rom_data), .sink_enable(sink_enable), .sink_branch(sink_branch),
    .sink_branch_target(sink_branch_target),
    .src_instr(w_instr), .src_instr_pc(w_instr_pc), .src_valid(w_valid), .sink_ready(sink_ready)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: rom_word = 16'h1111;
      16'h0001: rom_word = 16'h2222;
      16'h0002: rom_word = 16'h3333;
      16'h0003: rom_word = 16'h4444;
      default:  rom_word = a ^ 16'h5A5A;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROMs sample their inputs mid-cycle, on the falling edge.
  initial begin rom_data = '0; w_rom_data = '0; end
  always @(negedge clk) begin
    if (rom_ren)   rom_data   <= rom_word(rom_addr);
    if (w_rom_ren) w_rom_data <= rom_word(w_rom_addr);
  end

  // Scoreboard: every accepted word on the main instance must be the next expected PC.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_checks++;
      if (rom_cen !== rom_ren) begin
        n_errors++;
        $display("FAIL cen_eq_ren: cen=%b ren=%b", rom_cen, rom_ren);
      end
      if (valid && sink_ready && !sink_branch) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_word: got pc=%h data=%h, expected no word", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e || instr !== rom_word(e)) begin
            n_errors++;
            $display("FAIL delivered_word: got pc=%h data=%h, expected pc=%h data=%h",
                     instr_pc, instr, e, rom_word(e));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic reset_dut();
    rst = 1'b1;
    sink_branch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d words still outstanding, expected 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || rom_ren !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle: valid=%b ren=%b, expected 0 0", name, valid, rom_ren);
    end
  endtask

  task automatic test_reset();
    sink_enable = 1'b0; sink_ready = 1'b1; sink_branch_target = '0;
    reset_dut();
    n_checks++;
    if (valid !== 1'b0 || rom_ren !== 1'b0 || rom_cen !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: valid=%b ren=%b cen=%b, expected 0 0 0", valid, rom_ren, rom_cen);
    end
    n_checks++;
    if (rom_addr !== 16'h0000 || w_rom_addr !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL reset_addr: addr=%h waddr=%h, expected 0000 fffe", rom_addr, w_rom_addr);
    end
    n_checks++;
    if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_instr: instr=%h pc=%h, expected 0000 0000", instr, instr_pc);
    end
  endtask

  task automatic test_basic();
    exp_q = {16'h0000, 16'h0001, 16'h0002, 16'h0003};
    sink_enable = 1'b1; sink_ready = 1'b1;
    reset_dut();
    mon_en = 1'b1;
    release_reset();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_checks++;
        if (valid !== 1'b0 || rom_ren !== 1'b1 || rom_addr !== 16'h0000) begin
          n_errors++;
          $display("FAIL basic_first_issue: valid=%b ren=%b addr=%h, expected 0 1 0000", valid, rom_ren, rom_addr);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'h1111) begin
          n_errors++;
          $display("FAIL basic_first_valid: valid=%b pc=%h data=%h, expected 1 0000 1111", valid, instr_pc, instr);
        end
      end
      if (k == 4) sink_enable = 1'b0;
    end
    wait_drain("basic", 30);
  endtask

  task automatic test_backpressure();
    exp_q = {16'h0000, 16'h0001, 16'h0002, 16'h0003};
    sink_enable = 1'b1; sink_ready = 1'b0;
    reset_dut();
    release_reset();
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        n_checks++;
        if (rom_ren !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_second_issue: ren=%b, expected 1", rom_ren);
        end
      end
      if (k == 3 || k == 4) begin
        n_checks++;
        if (rom_ren !== 1'b0 || valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'h1111) begin
          n_errors++;
          $display("FAIL bp_hold_k%0d: ren=%b valid=%b pc=%h data=%h, expected 0 1 0000 1111",
                   k, rom_ren, valid, instr_pc, instr);
        end
      end
      if (k == 5) sink_ready = 1'b1;
      if (k == 7) sink_enable = 1'b0;
    end
    wait_drain("backpressure", 30);
  endtask

  task automatic test_branch();
    exp_q = {16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0100, 16'h0101};
    sink_enable = 1'b1; sink_ready = 1'b1;
    reset_dut();
    release_reset();
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 6) sink_ready = 1'b0;
      if (k == 7) begin
        n_checks++;
        if (valid !== 1'b1 || instr_pc !== 16'h0004 || rom_ren !== 1'b0) begin
          n_errors++;
          $display("FAIL branch_full: valid=%b pc=%h ren=%b, expected 1 0004 0", valid, instr_pc, rom_ren);
        end
        sink_branch = 1'b1; sink_branch_target = 16'h0100; sink_ready = 1'b1;
      end
      if (k == 8) begin
        sink_branch = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || rom_ren !== 1'b1 || rom_addr !== 16'h0100) begin
          n_errors++;
          $display("FAIL branch_flush: valid=%b ren=%b addr=%h, expected 0 1 0100", valid, rom_ren, rom_addr);
        end
      end
      if (k == 9) begin
        sink_enable = 1'b0;
        n_checks++;
        if (valid !== 1'b1 || instr_pc !== 16'h0100) begin
          n_errors++;
          $display("FAIL branch_target: valid=%b pc=%h, expected 1 0100", valid, instr_pc);
        end
      end
    end
    wait_drain("branch", 30);
  endtask

  task automatic test_enable();
    exp_q = {16'h0000, 16'h0001};
    sink_enable = 1'b1; sink_ready = 1'b1;
    reset_dut();
    release_reset();
    repeat (2) @(posedge clk);
    #1 sink_enable = 1'b0;
    wait_drain("enable_stop", 30);
    exp_q = {16'h0002, 16'h0003};
    @(posedge clk); #1 sink_enable = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rom_ren !== 1'b1 || rom_addr !== 16'h0002) begin
      n_errors++;
      $display("FAIL enable_resume: ren=%b addr=%h, expected 1 0002", rom_ren, rom_addr);
    end
    @(posedge clk); #1 sink_enable = 1'b0;
    wait_drain("enable_resume", 30);
  endtask

  task automatic test_wrap();
    logic [15:0] wexp[4];
    int w_idx;
    wexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    w_idx = 0;
    exp_q = {16'h0000, 16'h0001, 16'h0002, 16'h0003};
    sink_enable = 1'b1; sink_ready = 1'b1;
    reset_dut();
    release_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 4) sink_enable = 1'b0;
      if (w_valid && sink_ready) begin
        n_checks++;
        if (w_idx >= 4) begin
          n_errors++;
          $display("FAIL wrap_extra: got pc=%h, expected no word", w_instr_pc);
        end else if (w_instr_pc !== wexp[w_idx] || w_instr !== rom_word(wexp[w_idx])) begin
          n_errors++;
          $display("FAIL wrap_word%0d: got pc=%h data=%h, expected pc=%h data=%h",
                   w_idx, w_instr_pc, w_instr, wexp[w_idx], rom_word(wexp[w_idx]));
        end
        w_idx++;
      end
    end
    n_checks++;
    if (w_idx != 4) begin
      n_errors++;
      $display("FAIL wrap_count: got %0d words, expected 4", w_idx);
    end
    wait_drain("wrap", 10);
  endtask

  task automatic test_async_reset();
    sink_enable = 1'b1; sink_ready = 1'b1;
    reset_dut();
    mon_en = 1'b0;
    release_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (valid !== 1'b0 || rom_ren !== 1'b0 || rom_cen !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: valid=%b ren=%b cen=%b, expected 0 0 0", valid, rom_ren, rom_cen);
    end
    n_checks++;
    if (rom_addr !== 16'h0000 || instr_pc !== 16'h0000) begin
      n_errors++;
      $display("FAIL async_reset_addr: addr=%h pc=%h, expected 0000 0000", rom_addr, instr_pc);
    end
    exp_q = {16'h0000, 16'h0001};
    mon_en = 1'b1;
    release_reset();
    repeat (2) @(posedge clk);
    #1 sink_enable = 1'b0;
    wait_drain("async_restart", 30);
  endtask

  initial begin
    rst = 1'b1;
    sink_enable = 1'b0; sink_branch = 1'b0; sink_branch_target = '0; sink_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_branch();
    test_enable();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
